pulse_checker: RTL and testbench
================================

Name: pulse_checker

Overview:
- Receive-side checker for the BIST pulse-train generator. Monitors the generator's `out` and `bist_end` lines and verifies the train: N_PULSES high pulses, each exactly N_HIGH cycles, separated by exactly LOW_LEN low cycles, then `bist_end`.
- Reports pass/fail, an error code and the count of good pulses.
- Sits beside the generator in the BIST wrapper. Also usable standalone in benches as a self-checking monitor.

Parameters:
- N_HIGH, 8, required high length of each pulse in clk cycles (1..14).
- LOW_LEN, 1, required low gap between consecutive pulses in cycles (1..14).
- N_PULSES, 10, pulses per train (1..15).
- START_TIMEOUT, 255, maximum cycles in WAIT_H before the first rising edge (8-bit).
- END_TIMEOUT, 4, maximum cycles in END_WAIT for `bist_end_in` (8-bit).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- arm  input  1  one-cycle strobe; clears results and starts a check.
- pulse_in  input  1  generator pulse output, synchronous to clk.
- bist_end_in  input  1  generator completion flag.
- busy  output  1  high from the cycle after `arm` until `done`.
- done  output  1  check finished; held until next `arm` or reset.
- pass  output  1  done with err_code == 0.
- err_code  output  3  0 NONE, 1 HIGH_SHORT, 2 HIGH_LONG, 3 GAP_LONG, 4 EXTRA, 5 NO_END, 6 EARLY_END, 7 NO_START.
- pulse_cnt  output  4  number of pulses accepted with correct high length.

Behaviour:
- Reset:
  - state IDLE; busy, done, pass = 0; err_code = 0; pulse_cnt = 0; all internal counters 0.
  - Reset has priority over `arm`.
- States: IDLE, WAIT_H, MEAS_H, MEAS_L, END_WAIT, DONE.
- All decisions use the pulse_in/bist_end_in values sampled at the current edge. Results register at that edge and are visible the following cycle.
- `arm` in any state:
  - next state WAIT_H; clears done, pass, err_code, pulse_cnt and the timers; busy = 1.
  - If pulse_in = 1 on the arm cycle, it is ignored; a rising edge is required.
- WAIT_H:
  - pulse_in = 1 with previous sample 0 → MEAS_H, hcnt = 1.
  - bist_end_in = 1 → fail EARLY_END.
  - tcnt reaches START_TIMEOUT → fail NO_START.
- MEAS_H:
  - pulse_in = 1: hcnt++ (saturating at 15). If hcnt is already N_HIGH → fail HIGH_LONG.
  - pulse_in = 0 and hcnt < N_HIGH → fail HIGH_SHORT.
  - pulse_in = 0 and hcnt == N_HIGH → pulse_cnt++, then:
    - If this was pulse N_PULSES and bist_end_in = 1 → DONE pass.
    - If this was pulse N_PULSES and bist_end_in = 0 → END_WAIT.
    - Otherwise → MEAS_L, lcnt = 1.
  - bist_end_in = 1 on any other MEAS_H cycle → fail EARLY_END.
- MEAS_L:
  - pulse_in = 0: lcnt++. If lcnt is already LOW_LEN → fail GAP_LONG.
  - pulse_in = 1 and lcnt == LOW_LEN → MEAS_H, hcnt = 1.
  - pulse_in = 1 and lcnt < LOW_LEN → fail GAP_LONG. The code is shared for any gap mismatch.
  - bist_end_in = 1 → fail EARLY_END.
- END_WAIT:
  - pulse_in = 1 → fail EXTRA.
  - else bist_end_in = 1 → DONE pass.
  - else tcnt++; tcnt reaching END_TIMEOUT → fail NO_END.
- Fail means: next state DONE, err_code latched, pass = 0, done = 1, busy = 0.
- Simultaneous errors: the lowest nonzero code in the priority order listed for each state wins; EARLY_END is checked last.
- DONE:
  - Outputs held; pulse_in is ignored.
  - A second train without `arm` is not checked.
- pulse_cnt saturates at 15; it never wraps.
- Reset mid-check: returns to IDLE next edge; no result is reported.

Optional Feature:
- Macro: PULSE_CHECKER_CAPTURE_EN.
- Defined:
  - Adds output `fail_len[3:0]`: the hcnt or lcnt value at the failing sample, 0 for timeout, EXTRA and EARLY_END.
  - Adds output `fail_idx[3:0]`: pulse index (0-based) at failure.
  - Both cleared by reset and `arm`, and valid when done = 1 and pass = 0.
- Undefined: neither port nor its registers exist. All other behaviour is identical.

Decomposition:
- Shared params header holds:
  - state encodings and error-code localparams;
  - the default N_HIGH, LOW_LEN and N_PULSES, matching the generator's N_MAX/M_MAX-derived values.
- One sub-module: sat_counter.
  - Parameterised width; synchronous clear; enable; saturates at max.
  - Instantiated for hcnt, lcnt (4-bit) and tcnt (8-bit).
  - The FSM lives in pulse_checker.

Test Plan:
- Arm, then generator driven by a start pulse with defaults → done = 1, pass = 1, err_code = 0, pulse_cnt = 10, busy low the cycle after the final falling sample.
- Directed stimulus, 5th pulse high for 7 cycles → err_code = 1, pulse_cnt = 4, done the cycle after the falling sample.
- 3rd pulse high for 9 cycles → err_code = 2 on the 9th high sample, pulse_cnt = 2.
- 2-cycle gap after pulse 6 → err_code = 3, pulse_cnt = 6.
- 10 good pulses with bist_end_in held 0 → END_WAIT, err_code = 5 after 4 cycles.
- 10 good pulses followed by an 11th rising edge before bist_end_in → err_code = 4.
- Arm with pulse_in static 0 → err_code = 7 after 255 cycles.
- bist_end_in = 1 during pulse 3 → err_code = 6.
- Reset asserted during MEAS_H → all outputs 0 next cycle.
- Re-arm after a fail → a clean run passes.

Source files
------------

// File: rtl/pulse_checker_pkg.sv
// Shared definitions for the BIST pulse-train checker: state and error encodings,
// counter widths and the default train shape matching the generator.
package pulse_checker_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMR_W = 8;
  localparam int unsigned ERR_W = 3;

  // Defaults follow the generator's N_MAX/M_MAX-derived train shape
  localparam int unsigned DEF_N_HIGH        = 8;
  localparam int unsigned DEF_LOW_LEN       = 1;
  localparam int unsigned DEF_N_PULSES      = 10;
  localparam int unsigned DEF_START_TIMEOUT = 255;
  localparam int unsigned DEF_END_TIMEOUT   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_H,
    ST_MEAS_H,
    ST_MEAS_L,
    ST_END_WAIT,
    ST_DONE
  } state_t;

  localparam logic [ERR_W-1:0] ERR_NONE       = 3'd0;
  localparam logic [ERR_W-1:0] ERR_HIGH_SHORT = 3'd1;
  localparam logic [ERR_W-1:0] ERR_HIGH_LONG  = 3'd2;
  localparam logic [ERR_W-1:0] ERR_GAP_LONG   = 3'd3;
  localparam logic [ERR_W-1:0] ERR_EXTRA      = 3'd4;
  localparam logic [ERR_W-1:0] ERR_NO_END     = 3'd5;
  localparam logic [ERR_W-1:0] ERR_EARLY_END  = 3'd6;
  localparam logic [ERR_W-1:0] ERR_NO_START   = 3'd7;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pulse_checker_sat_counter.sv
// Saturating up-counter with synchronous clear and a restart-at-one load,
// used for the high, low and timeout counters of the pulse checker.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         start,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // start loads 1 because the sample that opens a phase is already its first cycle
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= W'(1);
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pulse_checker.sv
// Receive-side checker for the BIST pulse-train generator.
// Optional capture outputs fail_len/fail_idx are built when PULSE_CHECKER_CAPTURE_EN is defined.
module pulse_checker
  import pulse_checker_pkg::*;
#(
  parameter int unsigned N_HIGH        = DEF_N_HIGH,
  parameter int unsigned LOW_LEN       = DEF_LOW_LEN,
  parameter int unsigned N_PULSES      = DEF_N_PULSES,
  parameter int unsigned START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int unsigned END_TIMEOUT   = DEF_END_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             pulse_in,
  input  logic             bist_end_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_code,
  output logic [CNT_W-1:0] pulse_cnt
`ifdef PULSE_CHECKER_CAPTURE_EN
  ,
  output logic [CNT_W-1:0] fail_len,
  output logic [CNT_W-1:0] fail_idx
`endif
);

  localparam logic [CNT_W-1:0] N_HIGH_C     = CNT_W'(N_HIGH);
  localparam logic [CNT_W-1:0] LOW_LEN_C    = CNT_W'(LOW_LEN);
  localparam logic [CNT_W-1:0] LAST_PULSE_C = CNT_W'(N_PULSES - 1);
  localparam logic [TMR_W-1:0] START_LAST_C = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] END_LAST_C   = TMR_W'(END_TIMEOUT - 1);

  state_t state_q, state_d;
  logic   prev_pulse;
  logic   rise;

  logic [CNT_W-1:0] hcnt, lcnt;
  logic [TMR_W-1:0] tcnt;
  logic             h_start, h_en, l_start, l_en, t_en, t_clr;

  logic             fail;
  logic [ERR_W-1:0] fail_code;
  logic             busy_d, done_d, pass_d;
  logic [ERR_W-1:0] err_d;
  logic [CNT_W-1:0] cnt_d;

  assign rise  = pulse_in && !prev_pulse;
  // The timer only runs in the two waiting states and restarts on entry to either
  assign t_clr = arm || ((state_q != ST_WAIT_H) && (state_q != ST_END_WAIT));

  sat_counter #(.W(CNT_W)) u_hcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (arm),
    .start (h_start),
    .en    (h_en),
    .cnt   (hcnt)
  );

  sat_counter #(.W(CNT_W)) u_lcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (arm),
    .start (l_start),
    .en    (l_en),
    .cnt   (lcnt)
  );

  sat_counter #(.W(TMR_W)) u_tcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (t_clr),
    .start (1'b0),
    .en    (t_en),
    .cnt   (tcnt)
  );

  // State register and registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_code   <= ERR_NONE;
      pulse_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      prev_pulse <= pulse_in;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_code   <= err_d;
      pulse_cnt  <= cnt_d;
    end
  end

  // Next state, counter controls and result updates
  always_comb begin
    state_d   = state_q;
    pass_d    = pass;
    err_d     = err_code;
    cnt_d     = pulse_cnt;
    h_start   = 1'b0;
    h_en      = 1'b0;
    l_start   = 1'b0;
    l_en      = 1'b0;
    t_en      = 1'b0;
    fail      = 1'b0;
    fail_code = ERR_NONE;

    if (arm) begin
      state_d = ST_WAIT_H;
      pass_d  = 1'b0;
      err_d   = ERR_NONE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_WAIT_H: begin
          if (rise && !bist_end_in) begin
            state_d = ST_MEAS_H;
            h_start = 1'b1;
          end else if (!rise && (tcnt == START_LAST_C)) begin
            fail      = 1'b1;
            fail_code = ERR_NO_START;
          end else if (bist_end_in) begin
            fail      = 1'b1;
            fail_code = ERR_EARLY_END;
          end else begin
            t_en = 1'b1;
          end
        end

        ST_MEAS_H: begin
          if (pulse_in) begin
            if (hcnt == N_HIGH_C) begin
              fail      = 1'b1;
              fail_code = ERR_HIGH_LONG;
            end else if (bist_end_in) begin
              fail      = 1'b1;
              fail_code = ERR_EARLY_END;
            end else begin
              h_en = 1'b1;
            end
          end else if (hcnt < N_HIGH_C) begin
            fail      = 1'b1;
            fail_code = ERR_HIGH_SHORT;
          end else begin
            // Falling sample of a correctly sized pulse
            cnt_d = sat_inc(pulse_cnt);
            if (pulse_cnt == LAST_PULSE_C) begin
              if (bist_end_in) begin
                state_d = ST_DONE;
                pass_d  = 1'b1;
              end else begin
                state_d = ST_END_WAIT;
              end
            end else if (bist_end_in) begin
              fail      = 1'b1;
              fail_code = ERR_EARLY_END;
            end else begin
              state_d = ST_MEAS_L;
              l_start = 1'b1;
            end
          end
        end

        ST_MEAS_L: begin
          if (!pulse_in) begin
            if (lcnt == LOW_LEN_C) begin
              fail      = 1'b1;
              fail_code = ERR_GAP_LONG;
            end else if (bist_end_in) begin
              fail      = 1'b1;
              fail_code = ERR_EARLY_END;
            end else begin
              l_en = 1'b1;
            end
          end else if (lcnt != LOW_LEN_C) begin
            fail      = 1'b1;
            fail_code = ERR_GAP_LONG;
          end else if (bist_end_in) begin
            fail      = 1'b1;
            fail_code = ERR_EARLY_END;
          end else begin
            state_d = ST_MEAS_H;
            h_start = 1'b1;
          end
        end

        ST_END_WAIT: begin
          if (pulse_in) begin
            fail      = 1'b1;
            fail_code = ERR_EXTRA;
          end else if (bist_end_in) begin
            state_d = ST_DONE;
            pass_d  = 1'b1;
          end else if (tcnt == END_LAST_C) begin
            fail      = 1'b1;
            fail_code = ERR_NO_END;
          end else begin
            t_en = 1'b1;
          end
        end

        ST_IDLE, ST_DONE: ;

        default: state_d = ST_IDLE;
      endcase

      if (fail) begin
        state_d = ST_DONE;
        pass_d  = 1'b0;
        err_d   = fail_code;
      end
    end

    busy_d = (state_d == ST_WAIT_H) || (state_d == ST_MEAS_H) ||
             (state_d == ST_MEAS_L) || (state_d == ST_END_WAIT);
    done_d = (state_d == ST_DONE);
  end

`ifdef PULSE_CHECKER_CAPTURE_EN
  logic [CNT_W-1:0] fail_len_d, fail_idx_d;

  // Snapshot of the offending phase length and pulse index at the failing sample
  always_comb begin
    fail_len_d = fail_len;
    fail_idx_d = fail_idx;
    if (arm) begin
      fail_len_d = '0;
      fail_idx_d = '0;
    end else if (fail) begin
      fail_idx_d = pulse_cnt;
      if ((fail_code == ERR_HIGH_SHORT) || (fail_code == ERR_HIGH_LONG)) begin
        fail_len_d = hcnt;
      end else if (fail_code == ERR_GAP_LONG) begin
        fail_len_d = lcnt;
      end else begin
        fail_len_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fail_len <= '0;
      fail_idx <= '0;
    end else begin
      fail_len <= fail_len_d;
      fail_idx <= fail_idx_d;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_checker.sv
// Self-checking bench for pulse_checker: table of train scenarios driven as
// sample streams, expected results queued and compared when done rises.
module tb_pulse_checker;

  localparam int NH = 8;
  localparam int LL = 1;
  localparam int NP = 10;

  logic       clk = 1'b0;
  logic       reset, arm, pulse_in, bist_end_in;
  logic       busy, done, pass;
  logic [2:0] err_code;
  logic [3:0] pulse_cnt;
`ifdef PULSE_CHECKER_CAPTURE_EN
  logic [3:0] fail_len, fail_idx;
`endif

  always #5 clk = ~clk;

  pulse_checker dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .pulse_in    (pulse_in),
    .bist_end_in (bist_end_in),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_code    (err_code),
    .pulse_cnt   (pulse_cnt)
`ifdef PULSE_CHECKER_CAPTURE_EN
    ,
    .fail_len    (fail_len),
    .fail_idx    (fail_idx)
`endif
  );

  typedef struct {
    int odd_idx;    // pulse with non-nominal high length (-1 none)
    int odd_len;
    int gap_idx;    // gap after this pulse is gap_len (-1 none)
    int gap_len;
    int end_mode;   // 0 end on last fall, 1 never, 2 extra pulse, 3 end 2 cycles late
    int early_idx;  // bist_end on 3rd high sample of this pulse (-1 none)
    int exp_err;
    int exp_cnt;
    int exp_pass;
  } vec_t;

  typedef struct {
    int err;
    int cnt;
    int pass;
  } res_t;

  int         checks = 0;
  int         errors = 0;
  res_t       sb[$];
  logic [1:0] stim[$];
  int         exp_d;
  vec_t       vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic b);
    pulse_in    = p;
    bist_end_in = b;
  endtask

  // Builds the sample stream for a scenario and the index of the deciding sample
  task automatic build(input vec_t v);
    bit stop;
    int h, g;
    logic eb;
    stim.delete();
    exp_d = -1;
    stop  = 1'b0;
    stim.push_back(2'b00);
    stim.push_back(2'b00);
    for (int j = 0; j < NP; j++) begin
      h = (j == v.odd_idx) ? v.odd_len : NH;
      for (int k = 0; k < h; k++) begin
        eb = (j == v.early_idx) && (k == 2);
        stim.push_back({1'b1, eb});
        if (eb || (k == NH)) begin
          exp_d = stim.size() - 1;
          stop  = 1'b1;
          break;
        end
      end
      if (stop) break;
      if (h < NH) begin
        stim.push_back(2'b00);
        exp_d = stim.size() - 1;
        break;
      end
      if (j < NP - 1) begin
        g = (j == v.gap_idx) ? v.gap_len : LL;
        for (int k = 0; k < LL; k++) stim.push_back(2'b00);
        if (g > LL) begin
          stim.push_back(2'b00);
          exp_d = stim.size() - 1;
          break;
        end
      end else begin
        case (v.end_mode)
          0: stim.push_back(2'b01);
          1: repeat (5) stim.push_back(2'b00);
          2: begin stim.push_back(2'b00); stim.push_back(2'b00); stim.push_back(2'b10); end
          default: begin stim.push_back(2'b00); stim.push_back(2'b00); stim.push_back(2'b01); end
        endcase
        exp_d = stim.size() - 1;
      end
    end
    repeat (3) stim.push_back(2'b00);
  endtask

  task automatic arm_dut(input string name, input logic p);
    arm = 1'b1;
    drive(p, 1'b0);
    step();
    arm = 1'b0;
    chk({name, "_busy_after_arm"}, busy, 1);
    chk({name, "_done_cleared"}, done, 0);
  endtask

  task automatic check_result(input string name, output res_t r);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty actual=0 expected=1", name);
      r = '{0, 0, 0};
    end else begin
      r = sb.pop_front();
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_err"}, err_code, r.err);
    chk({name, "_cnt"}, pulse_cnt, r.cnt);
    chk({name, "_pass"}, pass, r.pass);
    chk({name, "_busy_low"}, busy, 0);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [1:0] s;
    int         got;
    res_t       r;
    build(v);
    sb.push_back('{v.exp_err, v.exp_cnt, v.exp_pass});
    arm_dut(name, 1'b0);
    got = -1;
    for (int i = 0; i < stim.size(); i++) begin
      s = stim[i];
      drive(s[1], s[0]);
      step();
      if (done) begin
        got = i;
        break;
      end
    end
    chk({name, "_done_sample"}, got, exp_d);
    check_result(name, r);
    // Further activity while in DONE must not disturb the result
    drive(1'b1, 1'b1);
    repeat (3) step();
    drive(1'b0, 1'b0);
    step();
    chk({name, "_hold_done"}, done, 1);
    chk({name, "_hold_err"}, err_code, r.err);
    chk({name, "_hold_cnt"}, pulse_cnt, r.cnt);
  endtask

  initial begin
    res_t r;
    int   n;
    //          odd  len gap glen end early err cnt pass
    vecs[0] = '{-1,  8, -1, 1,   0,  -1,   0, 10, 1};
    vecs[1] = '{ 4,  7, -1, 1,   0,  -1,   1,  4, 0};
    vecs[2] = '{ 2,  9, -1, 1,   0,  -1,   2,  2, 0};
    vecs[3] = '{-1,  8,  5, 2,   0,  -1,   3,  6, 0};
    vecs[4] = '{-1,  8, -1, 1,   1,  -1,   5, 10, 0};
    vecs[5] = '{-1,  8, -1, 1,   2,  -1,   4, 10, 0};
    vecs[6] = '{-1,  8, -1, 1,   0,   2,   6,  2, 0};
    vecs[7] = '{-1,  8, -1, 1,   3,  -1,   0, 10, 1};
    vecs[8] = '{ 0,  1, -1, 1,   0,  -1,   1,  0, 0};

    reset = 1'b1;
    arm   = 1'b0;
    drive(1'b0, 1'b0);
    repeat (2) step();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_err", err_code, 0);
    chk("reset_cnt", pulse_cnt, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Pulse held high across arm: no rising edge, so the start timer expires
    sb.push_back('{7, 0, 0});
    arm_dut("no_start", 1'b1);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (done) begin
        n = i;
        break;
      end
    end
    chk("no_start_cycles", n, 255);
    check_result("no_start", r);

    // Reset in the middle of the second pulse, with arm asserted alongside
    arm_dut("mid_reset", 1'b0);
    drive(1'b0, 1'b0);
    repeat (2) step();
    drive(1'b1, 1'b0);
    repeat (NH) step();
    drive(1'b0, 1'b0);
    repeat (LL) step();
    drive(1'b1, 1'b0);
    repeat (3) step();
    chk("mid_reset_cnt_before", pulse_cnt, 1);
    reset = 1'b1;
    arm   = 1'b1;
    step();
    arm   = 1'b0;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_done", done, 0);
    chk("mid_reset_pass", pass, 0);
    chk("mid_reset_err", err_code, 0);
    chk("mid_reset_cnt", pulse_cnt, 0);
    reset = 1'b0;
    drive(1'b0, 1'b0);
    step();

    run_vec("rearm_clean", vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
